// File: rtl/gmsk_pkg.sv
// Shared GMSK constants: sample width, oversampling, derived datapath widths and bit polarity.
// gmsk_tx and gmsk_rx both import this package.
package gmsk_pkg;
  localparam int BITS_PER_SAMPLE    = 8;
  localparam int SAMPLES_PER_SYMBOL = 4;
  localparam int CONF_THRESHOLD     = 64;
  localparam int PROD_W             = 2*BITS_PER_SAMPLE + 1;
  localparam int ACC_W              = PROD_W + $clog2(SAMPLES_PER_SYMBOL);
  // Bit value carried by counter-clockwise (positive) phase rotation.
  localparam logic BIT_CCW          = 1'b1;
endpackage

// File: rtl/gmsk_phase_disc.sv
// Cross-product phase discriminator: prod = prev_i*q - prev_q*i at full precision,
// registered together with a one-cycle valid for every accepted I/Q pair.
module gmsk_phase_disc #(
  parameter int BPS = gmsk_pkg::BITS_PER_SAMPLE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  accept_i,
  input  logic signed [BPS-1:0] i_i,
  input  logic signed [BPS-1:0] q_i,
  output logic signed [2*BPS:0] prod_o,
  output logic                  prod_valid_o
);
  localparam int PW = 2*BPS + 1;

  logic signed [BPS-1:0] prev_i_q, prev_q_q;
  logic signed [PW-1:0]  pi_x, pq_x, ci_x, cq_x, prod_d, prod_q;
  logic                  vld_q;

  // Sign-extend before multiplying so the -2^(BPS-1) corner cannot wrap.
  assign pi_x   = {{(PW-BPS){prev_i_q[BPS-1]}}, prev_i_q};
  assign pq_x   = {{(PW-BPS){prev_q_q[BPS-1]}}, prev_q_q};
  assign ci_x   = {{(PW-BPS){i_i[BPS-1]}}, i_i};
  assign cq_x   = {{(PW-BPS){q_i[BPS-1]}}, q_i};
  assign prod_d = pi_x*cq_x - pq_x*ci_x;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_i_q <= '0;
      prev_q_q <= '0;
      prod_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= accept_i;
      if (accept_i) begin
        prod_q   <= prod_d;
        prev_i_q <= i_i;
        prev_q_q <= q_i;
      end
    end
  end

  assign prod_o       = prod_q;
  assign prod_valid_o = vld_q;
endmodule

// File: rtl/gmsk_rx.sv
// GMSK demodulator: cross-product discriminator, integrate-and-dump over one symbol,
// sign slicer with a confidence flag. Symbol timing comes from symbol_align.
module gmsk_rx #(
  parameter int BITS_PER_SAMPLE    = gmsk_pkg::BITS_PER_SAMPLE,
  parameter int SAMPLES_PER_SYMBOL = gmsk_pkg::SAMPLES_PER_SYMBOL,
  parameter int CONF_THRESHOLD     = gmsk_pkg::CONF_THRESHOLD
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic signed [BITS_PER_SAMPLE-1:0] inphase_in,
  input  logic signed [BITS_PER_SAMPLE-1:0] quadrature_in,
  input  logic                              inphase_strobe,
  input  logic                              quadrature_strobe,
  input  logic                              symbol_align,
  output logic                              output_bit,
  output logic                              output_bit_strobe,
  output logic                              low_confidence,
  output logic                              strobe_error
);
  import gmsk_pkg::*;

  localparam int PW  = 2*BITS_PER_SAMPLE + 1;
  localparam int AW  = PW + $clog2(SAMPLES_PER_SYMBOL);
  localparam int PHW = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [PHW-1:0] PH_LAST = PHW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [AW:0]    THR     = (AW+1)'(CONF_THRESHOLD);

  logic                 accept, mismatch;
  logic signed [PW-1:0] prod;
  logic                 prod_valid, align_q;
  logic [PHW-1:0]       phase_q, phase_d, ph_eff;
  logic signed [AW-1:0] acc_q, acc_d, prod_x;
  logic                 dump_q, dump_d;
  logic                 bit_q, lc_q, strb_q, serr_q;
  logic signed [AW:0]   acc_x;
  logic [AW:0]          mag;

  assign accept   = clk_en & inphase_strobe & quadrature_strobe;
  assign mismatch = clk_en & (inphase_strobe ^ quadrature_strobe);

  gmsk_phase_disc #(.BPS(BITS_PER_SAMPLE)) u_disc (
    .clock        (clock),
    .reset        (reset),
    .accept_i     (accept),
    .i_i          (inphase_in),
    .q_i          (quadrature_in),
    .prod_o       (prod),
    .prod_valid_o (prod_valid)
  );

  // Alignment travels alongside the product so it lands on the same sample.
  assign ph_eff = align_q ? '0 : phase_q;
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    dump_d  = 1'b0;
    if (prod_valid) begin
      acc_d   = ((ph_eff == '0) ? '0 : acc_q) + prod_x;
      phase_d = (ph_eff == PH_LAST) ? '0 : ph_eff + 1'b1;
      dump_d  = (ph_eff == PH_LAST);
    end
  end

  assign acc_x = {acc_q[AW-1], acc_q};
  assign mag   = acc_x[AW] ? -acc_x : acc_x;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      align_q <= 1'b0;
      phase_q <= '0;
      acc_q   <= '0;
      dump_q  <= 1'b0;
      bit_q   <= 1'b0;
      lc_q    <= 1'b0;
      strb_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      align_q <= accept & symbol_align;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      dump_q  <= dump_d;
      strb_q  <= dump_q;
      if (dump_q) begin
        // Zero accumulator decides the non-CCW bit.
        bit_q <= (!acc_q[AW-1] && (acc_q != '0)) ? BIT_CCW : ~BIT_CCW;
        lc_q  <= (mag < THR);
      end
      if (mismatch) serr_q <= 1'b1;
    end
  end

  assign output_bit        = bit_q;
  assign low_confidence    = lc_q;
  assign output_bit_strobe = strb_q;
  assign strobe_error      = serr_q;
endmodule

// File: tb/tb_gmsk_rx.sv
// Bench for gmsk_rx: table of rotation windows, hand-written corner sequences and
// randomized traffic, all scored against a window-sum reference model.
module tb_gmsk_rx;
  localparam int SPS = 4;
  localparam int THR = 64;

  logic clock = 1'b0, reset = 1'b1;
  logic clk_en = 1'b0, istb = 1'b0, qstb = 1'b0, align = 1'b0;
  logic signed [7:0] iin = '0, qin = '0;
  logic output_bit, output_bit_strobe, low_confidence, strobe_error;

  always #5 clock = ~clock;

  gmsk_rx dut (
    .clock             (clock),
    .reset             (reset),
    .clk_en            (clk_en),
    .inphase_in        (iin),
    .quadrature_in     (qin),
    .inphase_strobe    (istb),
    .quadrature_strobe (qstb),
    .symbol_align      (align),
    .output_bit        (output_bit),
    .output_bit_strobe (output_bit_strobe),
    .low_confidence    (low_confidence),
    .strobe_error      (strobe_error)
  );

  typedef struct { bit b; bit lc; int due; } exp_t;
  typedef struct { int amp; int step; bit eb; bit elc; } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  exp_t expq[$];
  exp_t ce;
  longint win[$];
  longint prev_i = 0, prev_q = 0;
  bit exp_serr = 1'b0;
  int dec_cnt = 0;
  bit last_b, last_lc;
  bit got_bits[$];
  int ph = 0;
  int C[16] = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
  vec_t tbl[6];

  task automatic chk(string nm, longint got, longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // One clock: apply inputs, let the model see the accepting edge, return at the next negedge.
  task automatic drv(int i, int q, bit si, bit sq, bit en, bit al);
    longint p, s;
    exp_t e;
    iin = 8'(i); qin = 8'(q); istb = si; qstb = sq; clk_en = en; align = al;
    @(posedge clock);
    if (!reset) begin
      if (en && si && sq) begin
        p = prev_i*longint'(q) - prev_q*longint'(i);
        if (al) win.delete();
        win.push_back(p);
        prev_i = i; prev_q = q;
        if (win.size() == SPS) begin
          s = 0;
          foreach (win[k]) s += win[k];
          e.b = (s > 0); e.lc = ((s < 0) ? -s : s) < THR; e.due = cyc + 3;
          expq.push_back(e);
          win.delete();
        end
      end else if (en && (si != sq)) exp_serr = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic idle(int n);
    repeat (n) drv(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rot(int amp, int step, bit al);
    ph = (ph + step + 16) % 16;
    drv(amp*C[ph]/100, amp*C[(ph+12)%16]/100, 1'b1, 1'b1, 1'b1, al);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    win.delete(); expq.delete(); prev_i = 0; prev_q = 0; exp_serr = 1'b0;
    #1;
    chk("rst_bit", output_bit, 0);
    chk("rst_strobe", output_bit_strobe, 0);
    chk("rst_lowconf", low_confidence, 0);
    chk("rst_serr", strobe_error, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial forever begin
    @(posedge clock);
    cyc <= cyc + 1;
  end

  // Scoreboard: every decision must match the model's next window, on its due cycle.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      chk("strobe_error", strobe_error, exp_serr);
      if (output_bit_strobe) begin
        dec_cnt++; last_b = output_bit; last_lc = low_confidence;
        got_bits.push_back(output_bit);
        if (expq.size() == 0) chk("strobe_expected_q", expq.size(), 1);
        else begin
          ce = expq.pop_front();
          chk("strobe_cycle", cyc, ce.due);
          chk("dec_bit", output_bit, ce.b);
          chk("dec_lowconf", low_confidence, ce.lc);
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        chk("strobe_present", output_bit_strobe, 1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    int dc;
    int fi[5], fq[5];
    bit pat[4];
    tbl[0] = '{amp:100, step:1,  eb:1'b1, elc:1'b0};
    tbl[1] = '{amp:100, step:-1, eb:1'b0, elc:1'b0};
    tbl[2] = '{amp:2,   step:4,  eb:1'b1, elc:1'b1};
    tbl[3] = '{amp:2,   step:-4, eb:1'b0, elc:1'b1};
    tbl[4] = '{amp:127, step:8,  eb:1'b0, elc:1'b1};
    tbl[5] = '{amp:100, step:2,  eb:1'b1, elc:1'b0};

    #7;
    chk("init_bit", output_bit, 0);
    chk("init_strobe", output_bit_strobe, 0);
    chk("init_lowconf", low_confidence, 0);
    chk("init_serr", strobe_error, 0);
    @(negedge clock);
    reset = 1'b0;

    // Two back-to-back windows per row; the second is fully inside the row's rotation.
    foreach (tbl[r]) begin
      dc = dec_cnt;
      for (int k = 0; k < 2*SPS; k++) rot(tbl[r].amp, tbl[r].step, k == 0);
      idle(4);
      chk("tbl_count", dec_cnt - dc, 2);
      chk("tbl_bit", last_b, tbl[r].eb);
      chk("tbl_lowconf", last_lc, tbl[r].elc);
    end

    // Asynchronous reset mid-window, then with a decision in flight.
    rot(100, 1, 1'b1); rot(100, 1, 1'b0);
    #2; do_reset();
    for (int k = 0; k < SPS; k++) rot(100, 1, k == 0);
    #1; do_reset();
    dc = dec_cnt;
    for (int k = 0; k < SPS-1; k++) rot(100, 1, 1'b0);
    idle(6);
    chk("no_partial_after_rst", dec_cnt, dc);
    rot(100, 1, 1'b0);
    idle(4);
    chk("fresh_window_after_rst", dec_cnt, dc + 1);

    // Pattern 1,0,1,1 with clk_en toggling; idle cycles carry junk strobes.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    got_bits.delete();
    foreach (pat[b]) for (int s = 0; s < SPS; s++) begin
      drv(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      rot(100, pat[b] ? 1 : -1, b == 0 && s == 0);
    end
    idle(5);
    chk("gap_count", got_bits.size(), 4);
    foreach (pat[b]) if (b < got_bits.size()) chk("gap_bit", got_bits[b], pat[b]);

    // Realign on phase 2: partial window discarded, decision 4 accepted samples later.
    dc = dec_cnt;
    rot(100, 1, 1'b1); rot(100, 1, 1'b0);
    rot(100, 1, 1'b1);
    drv(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    drv(55, 55, 1'b1, 1'b1, 1'b0, 1'b1);
    rot(100, 1, 1'b0); rot(100, 1, 1'b0);
    idle(5);
    chk("align_drop", dec_cnt, dc);
    rot(100, 1, 1'b0);
    idle(4);
    chk("align_decision", dec_cnt, dc + 1);

    // Random traffic with frequent full-scale values.
    for (int n = 0; n < 600; n++) begin
      int ri, rq;
      ri = ($urandom_range(3) == 0) ? (($urandom_range(1) == 1) ? 127 : -128) : int'($urandom_range(255)) - 128;
      rq = ($urandom_range(3) == 0) ? (($urandom_range(1) == 1) ? 127 : -128) : int'($urandom_range(255)) - 128;
      drv(ri, rq, 1'b1, 1'b1, $urandom_range(3) != 0, $urandom_range(15) == 0);
    end
    idle(4);

    // Full-scale CCW window: each product near 2^15, sum 130050.
    fi = '{127, -128, -128, 127, 127};
    fq = '{127, 127, -128, -128, 127};
    dc = dec_cnt;
    foreach (fi[k]) drv(fi[k], fq[k], 1'b1, 1'b1, 1'b1, k == 1);
    idle(4);
    chk("fullscale_bit", last_b, 1);
    chk("fullscale_lowconf", last_lc, 0);

    // Lone inphase strobe: sample dropped, sticky error until reset.
    dc = dec_cnt;
    rot(100, 1, 1'b1); rot(100, 1, 1'b0); rot(100, 1, 1'b0);
    drv(50, 50, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("serr_set", strobe_error, 1);
    rot(100, 1, 1'b0);
    idle(4);
    chk("mismatch_dropped", dec_cnt, dc + 1);
    chk("serr_sticky", strobe_error, 1);
    do_reset();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
